bogatyri_nonce_scheduler: RTL and testbench

Job-level sequencer for the parallel mining array. Accepts one nonce job (inclusive range) at a time and splits it into fixed-size chunks. Hands the chunks round-robin to idle workers, tracks outstanding chunks, and broadcasts an abort on the first found nonce or on an external abort (phoenix rebirth trigger). Sits between the job source and the 27-unit worker array.

---
 rtl/firebird_sched_pkg.sv | 22 ++
 rtl/bogatyri_nonce_scheduler_if.sv | 45 ++++
 rtl/bogatyri_rr_arbiter.sv | 30 +++
 rtl/bogatyri_nonce_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_bogatyri_nonce_scheduler.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/firebird_sched_pkg.sv
// Shared types and defaults for the nonce scheduler: FSM state encoding,
// array geometry defaults and the nonce width.
package firebird_sched_pkg;

  localparam int DEF_NUM_WORKERS = 27;
  localparam int DEF_CHUNK_LEN   = 4096;
  localparam int NONCE_WIDTH     = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_DRAIN,
    ST_ABORT,
    ST_DONE
  } sched_state_t;

  // Index width that stays legal for a single-entry array.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bogatyri_nonce_scheduler_if.sv
// Job and worker-array bus of the nonce scheduler. The master modport is the
// scheduler side; the slave modport is the job source plus worker array.
interface bogatyri_nonce_scheduler_if
  import firebird_sched_pkg::*;
#(
  parameter int NUM_WORKERS = DEF_NUM_WORKERS,
  parameter int NONCE_W     = NONCE_WIDTH,
  parameter int CHUNK_LEN   = DEF_CHUNK_LEN
);
  localparam int LEN_W = $clog2(CHUNK_LEN) + 1;

  logic                           job_valid;
  logic                           job_ready;
  logic [NONCE_W-1:0]             job_base;
  logic [NONCE_W-1:0]             job_end;
  logic                           abort;
  logic [NUM_WORKERS-1:0]         wkr_req;
  logic [NUM_WORKERS-1:0]         wkr_grant;
  logic [NONCE_W-1:0]             wkr_base;
  logic [LEN_W-1:0]               wkr_len;
  logic [NUM_WORKERS-1:0]         wkr_done;
  logic [NUM_WORKERS-1:0]         wkr_found;
  logic [NUM_WORKERS*NONCE_W-1:0] wkr_nonce;
  logic                           wkr_abort;
  logic                           busy;
  logic                           done;
  logic                           found;
  logic [NONCE_W-1:0]             found_nonce;
  logic [31:0]                    stat_chunks;

  modport master (
    input  job_valid, job_base, job_end, abort,
    input  wkr_req, wkr_done, wkr_found, wkr_nonce,
    output job_ready, wkr_grant, wkr_base, wkr_len, wkr_abort,
    output busy, done, found, found_nonce, stat_chunks
  );

  modport slave (
    output job_valid, job_base, job_end, abort,
    output wkr_req, wkr_done, wkr_found, wkr_nonce,
    input  job_ready, wkr_grant, wkr_base, wkr_len, wkr_abort,
    input  busy, done, found, found_nonce, stat_chunks
  );

endinterface

// File: rtl/bogatyri_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after the pointer wins.
// Zero latency; holds no state, the pointer is owned by the caller.
module bogatyri_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] winner,
  output logic          any_grant
);

  always_comb begin : pick
    int idx;
    grant     = '0;
    winner    = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(pointer) + k) % N;
      if (!any_grant && req[idx]) begin
        any_grant   = 1'b1;
        grant[idx]  = 1'b1;
        winner      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/bogatyri_nonce_scheduler.sv
// Splits one inclusive nonce range into chunks granted round-robin to idle workers; one grant per cycle,
// registered outputs, job_ready only in IDLE. Optional grant counter under FIREBIRD_SCHED_STATS_EN.
module bogatyri_nonce_scheduler
  import firebird_sched_pkg::*;
#(
  parameter int NUM_WORKERS = DEF_NUM_WORKERS,
  parameter int NONCE_W     = NONCE_WIDTH,
  parameter int CHUNK_LEN   = DEF_CHUNK_LEN
) (
  input logic                         clk,
  input logic                         rst,
  bogatyri_nonce_scheduler_if.master  bus
);

  localparam int LEN_W = $clog2(CHUNK_LEN) + 1;
  localparam int IDX_W = idx_w(NUM_WORKERS);
  localparam int CUR_W = NONCE_W + 1;

  sched_state_t           state;
  logic [NUM_WORKERS-1:0] outstanding;
  logic [IDX_W-1:0]       rr_ptr;
  logic [CUR_W-1:0]       cursor;
  logic [NONCE_W-1:0]     job_end_q;

  logic                   job_ready_q;
  logic [NUM_WORKERS-1:0] grant_q;
  logic [NONCE_W-1:0]     base_q;
  logic [LEN_W-1:0]       len_q;
  logic                   abort_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   found_q;
  logic [NONCE_W-1:0]     nonce_q;

  logic [NUM_WORKERS-1:0] eligible;
  logic [NUM_WORKERS-1:0] arb_grant;
  logic [IDX_W-1:0]       arb_winner;
  logic                   arb_any;
  logic [IDX_W-1:0]       ptr_nxt;
  logic [CUR_W-1:0]       remaining;
  logic [LEN_W-1:0]       chunk_len;
  logic [CUR_W-1:0]       cursor_adv;
  logic                   active;
  logic [NUM_WORKERS-1:0] find_hit;
  logic                   find_any;
  logic [NONCE_W-1:0]     find_nonce;
  logic                   stop_req;
  logic                   do_grant;
  logic [NUM_WORKERS-1:0] outstanding_nxt;

  assign eligible = bus.wkr_req & ~outstanding;

  bogatyri_rr_arbiter #(
    .N  (NUM_WORKERS),
    .IW (IDX_W)
  ) u_arb (
    .req       (eligible),
    .pointer   (rr_ptr),
    .grant     (arb_grant),
    .winner    (arb_winner),
    .any_grant (arb_any)
  );

  assign ptr_nxt = (arb_winner == IDX_W'(NUM_WORKERS - 1)) ? '0 : arb_winner + IDX_W'(1);

  // 33-bit range math so a job ending at the top nonce terminates instead of wrapping.
  assign remaining  = {1'b0, job_end_q} - cursor + CUR_W'(1);
  assign chunk_len  = (remaining > CUR_W'(CHUNK_LEN)) ? LEN_W'(CHUNK_LEN) : remaining[LEN_W-1:0];
  assign cursor_adv = cursor + CUR_W'(chunk_len);

  assign active   = (state == ST_DISPATCH) || (state == ST_DRAIN);
  assign find_hit = bus.wkr_found & outstanding;
  assign find_any = active && (|find_hit);
  assign stop_req = active && (find_any || bus.abort);
  assign do_grant = (state == ST_DISPATCH) && arb_any && !stop_req;

  always_comb begin
    find_nonce = '0;
    for (int i = NUM_WORKERS - 1; i >= 0; i--) begin
      if (find_hit[i]) find_nonce = bus.wkr_nonce[i*NONCE_W +: NONCE_W];
    end
  end

  assign outstanding_nxt = (outstanding & ~(bus.wkr_done | bus.wkr_found))
                         | (do_grant ? arb_grant : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      outstanding <= '0;
      rr_ptr      <= '0;
      cursor      <= '0;
      job_end_q   <= '0;
      job_ready_q <= 1'b0;
      grant_q     <= '0;
      base_q      <= '0;
      len_q       <= '0;
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      nonce_q     <= '0;
    end else begin
      grant_q     <= '0;
      done_q      <= 1'b0;
      outstanding <= outstanding_nxt;
      case (state)
        ST_IDLE: begin
          job_ready_q <= 1'b1;
          if (bus.job_valid && job_ready_q) begin
            job_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            job_end_q   <= bus.job_end;
            cursor      <= {1'b0, bus.job_base};
            found_q     <= 1'b0;
            nonce_q     <= '0;
            if (bus.job_end >= bus.job_base) begin
              state <= ST_DISPATCH;
            end else begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end
          end
        end
        ST_DISPATCH, ST_DRAIN: begin
          if (stop_req) begin
            state   <= ST_ABORT;
            abort_q <= 1'b1;
            if (find_any) begin
              found_q <= 1'b1;
              nonce_q <= find_nonce;
            end
          end else if (state == ST_DISPATCH) begin
            if (do_grant) begin
              grant_q <= arb_grant;
              base_q  <= cursor[NONCE_W-1:0];
              len_q   <= chunk_len;
              cursor  <= cursor_adv;
              rr_ptr  <= ptr_nxt;
              if (cursor_adv > {1'b0, job_end_q}) state <= ST_DRAIN;
            end
          end else if (outstanding_nxt == '0) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end
        end
        ST_ABORT: begin
          if (outstanding_nxt == '0) begin
            state   <= ST_DONE;
            done_q  <= 1'b1;
            abort_q <= 1'b0;
          end
        end
        ST_DONE: begin
          state       <= ST_IDLE;
          busy_q      <= 1'b0;
          job_ready_q <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FIREBIRD_SCHED_STATS_EN
  logic [31:0] stat_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           stat_q <= '0;
    else if (do_grant) stat_q <= stat_q + 32'd1;
  end
  assign bus.stat_chunks = stat_q;
`else
  assign bus.stat_chunks = '0;
`endif

  assign bus.job_ready   = job_ready_q;
  assign bus.wkr_grant   = grant_q;
  assign bus.wkr_base    = base_q;
  assign bus.wkr_len     = len_q;
  assign bus.wkr_abort   = abort_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.found       = found_q;
  assign bus.found_nonce = nonce_q;

endmodule

// File: tb/tb_bogatyri_nonce_scheduler.sv
// Directed bench for the nonce scheduler: a table of jobs with hand-computed grants,
// plus find race, abort in DRAIN, mid-job reset and grant-counter sequences.
module tb_bogatyri_nonce_scheduler;
  import firebird_sched_pkg::*;

  localparam int NW  = 27;
  localparam int NWD = 32;
  localparam int CL  = 4096;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bogatyri_nonce_scheduler_if #(.NUM_WORKERS(NW), .NONCE_W(NWD), .CHUNK_LEN(CL)) bus ();

  bogatyri_nonce_scheduler #(.NUM_WORKERS(NW), .NONCE_W(NWD), .CHUNK_LEN(CL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] base;
    logic [31:0] last;
    int          n;
    int          first_len;
    int          last_len;
  } vec_t;

  vec_t vecs[6];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int onehot_bad = 0;
  bit auto_done = 1'b1;
  logic [NW-1:0] req_en = '1;
  bit held[NW];
  int cnt[NW];
  int g_wkr[$];
  logic [31:0] g_base[$];
  int g_len[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One clock: sample outputs #1 after the edge, then run the worker model.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    bus.wkr_done  = '0;
    bus.wkr_found = '0;
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if ($countones(bus.wkr_grant) > 1) onehot_bad++;
    for (int i = 0; i < NW; i++) begin
      if (bus.wkr_grant[i]) begin
        g_wkr.push_back(i);
        g_base.push_back(bus.wkr_base);
        g_len.push_back(int'(bus.wkr_len));
        held[i] = 1'b1;
        cnt[i] = LAT;
        bus.wkr_req[i] = 1'b0;
      end else if (held[i] && auto_done) begin
        if (cnt[i] == 0) begin
          bus.wkr_done[i] = 1'b1;
          held[i] = 1'b0;
          bus.wkr_req[i] = req_en[i];
        end else begin
          cnt[i]--;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.job_valid = 1'b0;
    bus.job_base  = '0;
    bus.job_end   = '0;
    bus.abort     = 1'b0;
    bus.wkr_req   = '0;
    bus.wkr_done  = '0;
    bus.wkr_found = '0;
    bus.wkr_nonce = '0;
    for (int i = 0; i < NW; i++) begin
      held[i] = 1'b0;
      cnt[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.wkr_req = req_en;
  endtask

  task automatic start_job(input logic [31:0] b, input logic [31:0] e);
    int w = 0;
    while (!bus.job_ready && w < 20) begin
      step();
      w++;
    end
    chk("job_ready_wait", 64'(bus.job_ready), 64'd1);
    g_wkr.delete();
    g_base.delete();
    g_len.delete();
    done_cnt = 0;
    bus.job_base  = b;
    bus.job_end   = e;
    bus.job_valid = 1'b1;
    step();
    bus.job_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(input int budget);
    int w = 0;
    while (done_cnt == 0 && w < budget) begin
      step();
      w++;
    end
    chk("done_timeout", 64'(done_cnt != 0), 64'd1);
  endtask

  task automatic wait_grants(input int n, input int budget);
    int w = 0;
    while (g_wkr.size() < n && w < budget) begin
      step();
      w++;
    end
    chk("grant_timeout", 64'(g_wkr.size()), 64'(n));
  endtask

  initial begin
    int exp_stat;
    vecs[0] = '{32'h0000_1000, 32'h0000_4FFF, 4, 4096, 4096};
    vecs[1] = '{32'hFFFF_FF00, 32'hFFFF_FFFF, 1, 256, 256};
    vecs[2] = '{32'h0000_0005, 32'h0000_0004, 0, 0, 0};
    vecs[3] = '{32'h0000_0010, 32'h0000_0010, 1, 1, 1};
    vecs[4] = '{32'h0000_0000, 32'h0000_1800, 2, 4096, 2049};
    vecs[5] = '{32'hFFFF_E000, 32'hFFFF_FFFF, 2, 4096, 4096};

    bus.job_valid = 1'b0;
    bus.job_base  = '0;
    bus.job_end   = '0;
    bus.abort     = 1'b0;
    bus.wkr_req   = '0;
    bus.wkr_done  = '0;
    bus.wkr_found = '0;
    bus.wkr_nonce = '0;
    #1;
    chk("reset_outputs", {bus.job_ready, bus.busy, bus.done, bus.found, bus.wkr_abort,
        |bus.wkr_grant, |bus.found_nonce, |bus.stat_chunks, |bus.wkr_base, |bus.wkr_len}, '0);

    // Table of jobs, each from a fresh reset so the round-robin pointer starts at 0.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      auto_done = 1'b1;
      start_job(vecs[v].base, vecs[v].last);
      wait_done(300);
      repeat (3) step();
      chk($sformatf("v%0d_grants", v), 64'(g_wkr.size()), 64'(vecs[v].n));
      chk($sformatf("v%0d_done_pulses", v), 64'(done_cnt), 64'd1);
      chk($sformatf("v%0d_found", v), 64'(bus.found), 64'd0);
      chk($sformatf("v%0d_ready_back", v), 64'(bus.job_ready), 64'd1);
      if (vecs[v].n == 0)
        chk($sformatf("v%0d_empty_latency", v), 64'(done_cyc - acc_cyc <= 2), 64'd1);
      for (int k = 0; k < g_wkr.size() && k < vecs[v].n; k++) begin
        chk($sformatf("v%0d_g%0d_worker", v, k), 64'(g_wkr[k]), 64'(k));
        chk($sformatf("v%0d_g%0d_base", v, k), 64'(g_base[k]), 64'(vecs[v].base + 32'(k * CL)));
      end
      if (g_len.size() > 0) begin
        chk($sformatf("v%0d_first_len", v), 64'(g_len[0]), 64'(vecs[v].first_len));
        chk($sformatf("v%0d_last_len", v), 64'(g_len[g_len.size()-1]), 64'(vecs[v].last_len));
      end
    end

    // Two finds in the same cycle: lowest worker index wins; later finds ignored.
    do_reset();
    auto_done = 1'b0;
    start_job(32'h0, 32'h9FFF);
    wait_grants(10, 100);
    bus.wkr_nonce[3*NWD +: NWD] = 32'hAA;
    bus.wkr_nonce[7*NWD +: NWD] = 32'hBB;
    bus.wkr_found[3] = 1'b1;
    bus.wkr_found[7] = 1'b1;
    step();
    chk("find_found", 64'(bus.found), 64'd1);
    chk("find_nonce", 64'(bus.found_nonce), 64'hAA);
    chk("find_abort", 64'(bus.wkr_abort), 64'd1);
    bus.wkr_nonce[5*NWD +: NWD] = 32'hCC;
    bus.wkr_found[5] = 1'b1;
    step();
    step();
    chk("find_late_ignored", 64'(bus.found_nonce), 64'hAA);
    chk("find_abort_held", 64'(bus.wkr_abort), 64'd1);
    chk("find_no_early_done", 64'(done_cnt), 64'd0);
    bus.wkr_done = 27'b0000_0000_0000_0011_0101_0111;
    step();
    chk("find_done", 64'(bus.done), 64'd1);
    chk("find_done_found", 64'(bus.found), 64'd1);
    chk("find_abort_clear", 64'(bus.wkr_abort), 64'd0);
    step();
    chk("find_ready", 64'(bus.job_ready), 64'd1);
    start_job(32'h5, 32'h4);
    chk("accept_clears_found", {63'd0, bus.found}, 64'd0);
    chk("accept_clears_nonce", 64'(bus.found_nonce), 64'd0);

    // External abort in DRAIN with two chunks outstanding.
    do_reset();
    auto_done = 1'b0;
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("idle_abort_ignored", {bus.busy, bus.wkr_abort}, 64'd0);
    start_job(32'h0, 32'h1FFF);
    wait_grants(2, 50);
    step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_raised", 64'(bus.wkr_abort), 64'd1);
    chk("abort_found", 64'(bus.found), 64'd0);
    step();
    step();
    bus.wkr_done[0] = 1'b1;
    step();
    chk("abort_wait", {bus.wkr_abort, bus.done}, 64'b10);
    bus.wkr_done[1] = 1'b1;
    step();
    chk("abort_done", {bus.done, bus.found, bus.wkr_abort}, 64'b100);

    // Reset in the middle of DISPATCH.
    do_reset();
    auto_done = 1'b1;
    start_job(32'h0, 32'h000F_FFFF);
    repeat (10) step();
    chk("midjob_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("midjob_reset_outputs", {bus.job_ready, bus.busy, bus.done, bus.found, bus.wkr_abort,
        |bus.wkr_grant, |bus.found_nonce, |bus.stat_chunks, |bus.wkr_base, |bus.wkr_len}, '0);
    do_reset();
    step();
    chk("midjob_ready_after", {bus.job_ready, bus.busy}, 64'b10);
    start_job(32'h1000, 32'h1FFF);
    wait_done(100);
    chk("midjob_ptr_reset", 64'((g_wkr.size() == 1) ? g_wkr[0] : -1), 64'd0);

    // Grant counter over three 27-chunk jobs.
    do_reset();
    auto_done = 1'b1;
    for (int j = 0; j < 3; j++) begin
      start_job(32'h0, 32'h0001_AFFF);
      wait_done(400);
      chk($sformatf("stats_job%0d_grants", j), 64'(g_wkr.size()), 64'd27);
    end
`ifdef FIREBIRD_SCHED_STATS_EN
    exp_stat = 81;
`else
    exp_stat = 0;
`endif
    chk("stat_chunks", 64'(bus.stat_chunks), 64'(exp_stat));
    chk("grant_onehot", 64'(onehot_bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
